pc_sequencer: RTL and testbench



---
 rtl/pc_pkg.sv | 35 +++
 rtl/pc_return_stack.sv | 53 +++++
 rtl/pc_sequencer.sv | 119 +++++++++++
 tb/tb_pc_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the instruction-fetch program counter.
// Command decode encodes the fixed priority complete > ret > call > w_en > inc.
package pc_pkg;

    localparam int unsigned PC_ADDR_W_DEFAULT      = 6;
    localparam int unsigned PC_STACK_DEPTH_DEFAULT = 4;

    typedef enum logic {
        PC_RUN,
        PC_HALT
    } pc_state_e;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_INC,
        CMD_JUMP,
        CMD_CALL,
        CMD_RET,
        CMD_COMPLETE
    } pc_cmd_e;

    function automatic pc_cmd_e pc_decode(input logic inc, input logic w_en,
                                          input logic call, input logic ret,
                                          input logic complete);
        pc_cmd_e cmd;
        cmd = CMD_NONE;
        if (complete)  cmd = CMD_COMPLETE;
        else if (ret)  cmd = CMD_RET;
        else if (call) cmd = CMD_CALL;
        else if (w_en) cmd = CMD_JUMP;
        else if (inc)  cmd = CMD_INC;
        return cmd;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Hardware return-address LIFO; push/pop are ignored when they would
// overflow/underflow and the event is flagged combinationally instead.
module pc_return_stack #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned SP_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  sp_dec;

    always_comb begin
        sp_dec    = sp - SP_W'(1);
        empty     = (sp == '0);
        full      = (sp == SP_W'(DEPTH));
        overflow  = push && full;
        underflow = pop && empty;
        top_data  = mem[sp_dec[IDX_W-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sp <= '0;
        else if (clear)
            sp <= '0;
        else if (push && !full)
            sp <= sp + SP_W'(1);
        else if (pop && !empty)
            sp <= sp_dec;
    end

    // Entry contents need no reset: only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[sp[IDX_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with call/return stack and RUN/HALT control.
// Optional macro PC_STACK_FAULT_HALT_EN: stack overflow/underflow also halts.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W      = PC_ADDR_W_DEFAULT,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned STACK_DEPTH = PC_STACK_DEPTH_DEFAULT,
    parameter int unsigned START_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              inc,
    input  logic              w_en,
    input  logic              call,
    input  logic              ret,
    input  logic              complete,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] instruction_address,
    output logic              halted,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
);

    pc_state_e         state;
    pc_cmd_e           cmd;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] ret_addr;
    logic              running;
    logic              push;
    logic              pop;
    logic              restart;
    logic              st_over;
    logic              st_under;
    logic              stack_fault;

    generate
        if (DATA_W > ADDR_W) begin : g_hi_bits
            logic unused_data_hi;
            assign unused_data_hi = ^data_in[DATA_W-1:ADDR_W];
        end
    endgenerate

    always_comb begin
        cmd         = pc_decode(inc, w_en, call, ret, complete);
        pc_inc      = instruction_address + ADDR_W'(1);
        target      = data_in[ADDR_W-1:0];
        running     = en && (state == PC_RUN);
        push        = running && (cmd == CMD_CALL);
        pop         = running && (cmd == CMD_RET);
        restart     = en && (state == PC_HALT) && start;
        stack_fault = st_over || st_under;
    end

    pc_return_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clear     (restart),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (ret_addr),
        .empty     (stack_empty),
        .full      (stack_full),
        .overflow  (st_over),
        .underflow (st_under)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= PC_RUN;
            instruction_address <= ADDR_W'(START_ADDR);
            halted              <= 1'b0;
            stack_err           <= 1'b0;
        end else if (en) begin
            unique case (state)
                PC_RUN: begin
                    unique case (cmd)
                        CMD_COMPLETE: begin
                            state  <= PC_HALT;
                            halted <= 1'b1;
                        end
                        CMD_RET, CMD_CALL: begin
                            if (stack_fault) begin
                                stack_err <= 1'b1;
`ifdef PC_STACK_FAULT_HALT_EN
                                state     <= PC_HALT;
                                halted    <= 1'b1;
`endif
                            end else begin
                                instruction_address <= (cmd == CMD_RET) ? ret_addr : target;
                            end
                        end
                        CMD_JUMP: instruction_address <= target;
                        CMD_INC:  instruction_address <= pc_inc;
                        default:  ;
                    endcase
                end
                PC_HALT: begin
                    if (start) begin
                        state               <= PC_RUN;
                        halted              <= 1'b0;
                        instruction_address <= ADDR_W'(START_ADDR);
                        stack_err           <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic against a queue-based reference model of the sequencer rules.
module tb_pc_sequencer;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;
`ifdef PC_STACK_FAULT_HALT_EN
    localparam bit FAULT_HALT = 1'b1;
`else
    localparam bit FAULT_HALT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0, inc = 1'b0, w_en = 1'b0, call = 1'b0;
    logic              ret = 1'b0, complete = 1'b0, start = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [ADDR_W-1:0] instruction_address;
    logic              halted, stack_empty, stack_full, stack_err;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] m_pc;
    bit                m_halted;
    bit                m_err;
    logic [ADDR_W-1:0] m_stack[$];

    pc_sequencer #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STACK_DEPTH (DEPTH),
        .START_ADDR  (0)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .en                  (en),
        .inc                 (inc),
        .w_en                (w_en),
        .call                (call),
        .ret                 (ret),
        .complete            (complete),
        .start               (start),
        .data_in             (data_in),
        .instruction_address (instruction_address),
        .halted              (halted),
        .stack_empty         (stack_empty),
        .stack_full          (stack_full),
        .stack_err           (stack_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pc = '0;
        m_halted = 1'b0;
        m_err = 1'b0;
        m_stack.delete();
    endfunction

    function automatic void model_step(bit e, bit i, bit w, bit c, bit r, bit cp, bit s,
                                       logic [DATA_W-1:0] d);
        if (!e) return;
        if (m_halted) begin
            if (s) begin
                m_halted = 1'b0;
                m_pc = '0;
                m_err = 1'b0;
                m_stack.delete();
            end
        end else if (cp) begin
            m_halted = 1'b1;
        end else if (r) begin
            if (m_stack.size() == 0) begin
                m_err = 1'b1;
                if (FAULT_HALT) m_halted = 1'b1;
            end else begin
                m_pc = m_stack.pop_back();
            end
        end else if (c) begin
            if (m_stack.size() == DEPTH) begin
                m_err = 1'b1;
                if (FAULT_HALT) m_halted = 1'b1;
            end else begin
                m_stack.push_back(m_pc + 6'd1);
                m_pc = d[ADDR_W-1:0];
            end
        end else if (w) begin
            m_pc = d[ADDR_W-1:0];
        end else if (i) begin
            m_pc = m_pc + 6'd1;
        end
    endfunction

    task automatic cyc(input bit e, input bit i, input bit w, input bit c, input bit r,
                       input bit cp, input bit s, input logic [DATA_W-1:0] d);
        en = e; inc = i; w_en = w; call = c; ret = r; complete = cp; start = s;
        data_in = d;
        model_step(e, i, w, c, r, cp, s, d);
        @(posedge clk);
        #1;
        en = 1'b0; inc = 1'b0; w_en = 1'b0; call = 1'b0; ret = 1'b0;
        complete = 1'b0; start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1; inc = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (instruction_address !== 6'd0) begin
            errors++; $display("FAIL reset_addr: got %0d expected 0", instruction_address);
        end
        checks++;
        if ({halted, stack_empty, stack_full, stack_err} !== 4'b0100) begin
            errors++; $display("FAIL reset_flags: got %b expected 0100",
                               {halted, stack_empty, stack_full, stack_err});
        end
        inc = 1'b0; en = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_inc();
        for (int k = 1; k <= 3; k++) begin
            cyc(1, 1, 0, 0, 0, 0, 0, '0);
            checks++;
            if (instruction_address !== 6'(k)) begin
                errors++; $display("FAIL inc_%0d: got %0d expected %0d", k, instruction_address, k);
            end
        end
        en = 1'b1; inc = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (instruction_address !== 6'd0) begin
            errors++; $display("FAIL async_reset: got %0d expected 0", instruction_address);
        end
        en = 1'b0; inc = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_jump();
        cyc(1, 0, 1, 0, 0, 0, 0, 32'hA5A5_A5A5);
        checks++;
        if (instruction_address !== 6'b100101) begin
            errors++; $display("FAIL jump_a5: got %b expected 100101", instruction_address);
        end
        cyc(1, 1, 0, 0, 0, 0, 0, '0);
        checks++;
        if (instruction_address !== 6'b100110) begin
            errors++; $display("FAIL jump_inc: got %b expected 100110", instruction_address);
        end
        cyc(1, 0, 1, 0, 0, 0, 0, 32'd63);
        cyc(1, 1, 0, 0, 0, 0, 0, '0);
        checks++;
        if (instruction_address !== 6'd0 || stack_err !== 1'b0) begin
            errors++; $display("FAIL wrap: got addr %0d err %b expected addr 0 err 0",
                               instruction_address, stack_err);
        end
    endtask

    task automatic test_nested_calls();
        cyc(1, 0, 1, 0, 0, 0, 0, 32'd5);
        cyc(1, 0, 0, 1, 0, 0, 0, 32'd20);
        checks++;
        if (instruction_address !== 6'd20 || stack_empty !== 1'b0) begin
            errors++; $display("FAIL call1: got addr %0d empty %b expected 20 0",
                               instruction_address, stack_empty);
        end
        cyc(1, 0, 0, 1, 0, 0, 0, 32'd40);
        checks++;
        if (instruction_address !== 6'd40) begin
            errors++; $display("FAIL call2: got %0d expected 40", instruction_address);
        end
        cyc(1, 0, 0, 0, 1, 0, 0, '0);
        checks++;
        if (instruction_address !== 6'd21) begin
            errors++; $display("FAIL ret1: got %0d expected 21", instruction_address);
        end
        cyc(1, 0, 0, 0, 1, 0, 0, '0);
        checks++;
        if (instruction_address !== 6'd6 || stack_empty !== 1'b1) begin
            errors++; $display("FAIL ret2: got addr %0d empty %b expected 6 1",
                               instruction_address, stack_empty);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 1, 0, 0, 0, 32'(10 + k));
        checks++;
        if (stack_full !== 1'b1 || instruction_address !== 6'd13) begin
            errors++; $display("FAIL full: got full %b addr %0d expected 1 13",
                               stack_full, instruction_address);
        end
        cyc(1, 0, 0, 1, 0, 0, 0, 32'd50);
        checks++;
        if (instruction_address !== 6'd13 || stack_err !== 1'b1 || halted !== FAULT_HALT) begin
            errors++; $display("FAIL overflow: got addr %0d err %b halted %b expected 13 1 %b",
                               instruction_address, stack_err, halted, FAULT_HALT);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        cyc(1, 0, 0, 0, 1, 0, 0, '0);
        checks++;
        if (instruction_address !== 6'd0 || stack_err !== 1'b1 || halted !== FAULT_HALT) begin
            errors++; $display("FAIL underflow: got addr %0d err %b halted %b expected 0 1 %b",
                               instruction_address, stack_err, halted, FAULT_HALT);
        end
    endtask

    task automatic test_priority();
        do_reset();
        cyc(1, 0, 1, 0, 0, 0, 0, 32'd9);
        cyc(1, 0, 0, 0, 1, 0, 0, '0);
        cyc(1, 1, 0, 0, 0, 1, 0, '0);
        checks++;
        if (halted !== 1'b1 || instruction_address !== 6'd9) begin
            errors++; $display("FAIL complete_inc: got halted %b addr %0d expected 1 9",
                               halted, instruction_address);
        end
        cyc(1, 1, 0, 0, 0, 0, 0, '0);
        cyc(1, 0, 0, 1, 0, 0, 0, 32'd33);
        checks++;
        if (halted !== 1'b1 || instruction_address !== 6'd9 || stack_empty !== 1'b1) begin
            errors++; $display("FAIL halt_ignore: got halted %b addr %0d empty %b expected 1 9 1",
                               halted, instruction_address, stack_empty);
        end
        cyc(1, 0, 0, 0, 0, 0, 1, '0);
        checks++;
        if (halted !== 1'b0 || instruction_address !== 6'd0 || stack_err !== 1'b0) begin
            errors++; $display("FAIL restart: got halted %b addr %0d err %b expected 0 0 0",
                               halted, instruction_address, stack_err);
        end
        cyc(1, 0, 0, 1, 0, 0, 0, 32'd30);
        cyc(1, 0, 0, 1, 1, 0, 0, 32'd50);
        checks++;
        if (instruction_address !== 6'd1 || stack_empty !== 1'b1) begin
            errors++; $display("FAIL ret_over_call: got addr %0d empty %b expected 1 1",
                               instruction_address, stack_empty);
        end
        cyc(1, 0, 0, 0, 0, 0, 1, '0);
        checks++;
        if (instruction_address !== 6'd1 || halted !== 1'b0) begin
            errors++; $display("FAIL start_in_run: got addr %0d halted %b expected 1 0",
                               instruction_address, halted);
        end
    endtask

    task automatic test_enable();
        do_reset();
        cyc(1, 0, 1, 0, 0, 0, 0, 32'd12);
        cyc(1, 0, 0, 1, 0, 0, 0, 32'd20);
        for (int k = 0; k < 6; k++) begin
            cyc(0, 1, 1, k[0], ~k[0], 1, 1, 32'($urandom));
            checks++;
            if ({instruction_address, halted, stack_empty, stack_full, stack_err} !== {6'd20, 4'b0000}) begin
                errors++; $display("FAIL en_low_%0d: got addr %0d flags %b expected 20 0000", k,
                                   instruction_address, {halted, stack_empty, stack_full, stack_err});
            end
        end
        cyc(1, 0, 0, 0, 0, 1, 0, '0);
        cyc(0, 0, 0, 0, 0, 0, 1, '0);
        checks++;
        if (halted !== 1'b1 || instruction_address !== 6'd20) begin
            errors++; $display("FAIL en_low_start: got halted %b addr %0d expected 1 20",
                               halted, instruction_address);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 2) == 0, 32'($urandom));
            checks++;
            if (instruction_address !== m_pc) begin
                errors++; $display("FAIL rnd_addr[%0d]: got %0d expected %0d", n, instruction_address, m_pc);
            end
            checks++;
            if (halted !== m_halted) begin
                errors++; $display("FAIL rnd_halted[%0d]: got %b expected %b", n, halted, m_halted);
            end
            checks++;
            if (stack_empty !== (m_stack.size() == 0)) begin
                errors++; $display("FAIL rnd_empty[%0d]: got %b expected %b", n, stack_empty, m_stack.size() == 0);
            end
            checks++;
            if (stack_full !== (m_stack.size() == DEPTH)) begin
                errors++; $display("FAIL rnd_full[%0d]: got %b expected %b", n, stack_full, m_stack.size() == DEPTH);
            end
            checks++;
            if (stack_err !== m_err) begin
                errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", n, stack_err, m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_inc();
        test_jump();
        test_nested_calls();
        test_overflow();
        test_underflow();
        test_priority();
        test_enable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
